// File: rtl/xnor_cmp_pipe_if.sv
// Operand/result handshake bundle for the pipelined XNOR compare stage.
// master drives operands and consumer ready; slave is the compare stage.
interface xnor_cmp_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    localparam int EQ_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [EQ_W-1:0]  eq_bits;
    logic             all_eq;
    logic [CNT_W-1:0] match_count;
    logic             clr_count;

    modport master (
        output in_valid,
        output a,
        output b,
        output mode,
        output out_ready,
        output clr_count,
        input  in_ready,
        input  out_valid,
        input  s,
        input  eq_bits,
        input  all_eq,
        input  match_count
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  mode,
        input  out_ready,
        input  clr_count,
        output in_ready,
        output out_valid,
        output s,
        output eq_bits,
        output all_eq,
        output match_count
    );
endinterface

// File: rtl/xnor_cmp_pipe.sv
// Two-stage XNOR/XOR compare with equal-bit count, word-equal flag
// and a saturating counter of fully-equal results.
module xnor_cmp_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    xnor_cmp_pipe_if.slave bus
);
    localparam int EQ_W = $clog2(WIDTH + 1);

    logic             r_v1;
    logic [WIDTH-1:0] r_eqv;
    logic             r_mode;

    logic             r_v2;
    logic [WIDTH-1:0] r_s;
    logic [EQ_W-1:0]  r_eqb;
    logic             r_all_eq;

    logic [CNT_W-1:0] r_cnt;

    logic             w_adv1;
    logic             w_adv2;
    logic [EQ_W-1:0]  w_pop;
    logic             w_cnt_inc;
    logic             w_cnt_sat;

    // A stage may load when it is empty or its content moves on.
    assign w_adv2 = !r_v2 || bus.out_ready;
    assign w_adv1 = !r_v1 || w_adv2;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + EQ_W'(r_eqv[i]);
        end
    end

    assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}});
    assign w_cnt_inc = r_v2 && bus.out_ready && r_all_eq && !w_cnt_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_eqv  <= '0;
            r_mode <= 1'b0;
        end else if (w_adv1) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_eqv  <= ~(bus.a ^ bus.b);
                r_mode <= bus.mode;
            end
        end
    end

    // Result registers only move with real data, so they stay put on bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2     <= 1'b0;
            r_s      <= '0;
            r_eqb    <= '0;
            r_all_eq <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s      <= r_mode ? ~r_eqv : r_eqv;
                r_eqb    <= w_pop;
                r_all_eq <= &r_eqv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clr_count) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = w_adv1;
    assign bus.out_valid   = r_v2;
    assign bus.s           = r_s;
    assign bus.eq_bits     = r_eqb;
    assign bus.all_eq      = r_all_eq;
    assign bus.match_count = r_cnt;
endmodule
